std_prbs_checker: RTL and testbench

STD_PRBS_CHECKER -- requirements
Module: std_prbs_checker

---
 rtl/std_lfsr_pkg.sv | 108 ++++++++++
 rtl/std_lfsr_galois.sv | 25 ++
 rtl/std_prbs_checker.sv | 158 +++++++++++++++
 tb/tb_std_prbs_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/std_lfsr_pkg.sv
// Shared LFSR helpers: default Galois tap table, single-step function and
// the PRBS checker state encoding.
package std_lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  // Fibonacci tap list (n plus up to five extra taps) mapped onto the
  // right-shifting Galois encoding: tap t lands on bit n-t-1.
  function automatic logic [LFSR_MAX_W-1:0] taps_from(input int n, input int t0,
                                                      input int t1, input int t2,
                                                      input int t3, input int t4);
    logic [LFSR_MAX_W-1:0] r;
    int                    t [5];
    t = '{t0, t1, t2, t3, t4};
    r = LFSR_MAX_W'(1) << (n - 1);
    for (int i = 0; i < 5; i++)
      if (t[i] > 0 && t[i] < n) r = r | (LFSR_MAX_W'(1) << (n - t[i] - 1));
    return r;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] taps_default(input int size);
    case (size)
      2:  return taps_from(2, 1, 0, 0, 0, 0);
      3:  return taps_from(3, 2, 0, 0, 0, 0);
      4:  return taps_from(4, 3, 0, 0, 0, 0);
      5:  return taps_from(5, 3, 0, 0, 0, 0);
      6:  return taps_from(6, 5, 0, 0, 0, 0);
      7:  return taps_from(7, 6, 0, 0, 0, 0);
      8:  return taps_from(8, 6, 5, 4, 0, 0);
      9:  return taps_from(9, 5, 0, 0, 0, 0);
      10: return taps_from(10, 7, 0, 0, 0, 0);
      11: return taps_from(11, 9, 0, 0, 0, 0);
      12: return taps_from(12, 6, 4, 1, 0, 0);
      13: return taps_from(13, 4, 3, 1, 0, 0);
      14: return taps_from(14, 5, 3, 1, 0, 0);
      15: return taps_from(15, 14, 0, 0, 0, 0);
      16: return taps_from(16, 15, 13, 4, 0, 0);
      17: return taps_from(17, 14, 0, 0, 0, 0);
      18: return taps_from(18, 11, 0, 0, 0, 0);
      19: return taps_from(19, 6, 2, 1, 0, 0);
      20: return taps_from(20, 17, 0, 0, 0, 0);
      21: return taps_from(21, 19, 0, 0, 0, 0);
      22: return taps_from(22, 21, 0, 0, 0, 0);
      23: return taps_from(23, 18, 0, 0, 0, 0);
      24: return taps_from(24, 23, 22, 17, 0, 0);
      25: return taps_from(25, 22, 0, 0, 0, 0);
      26: return taps_from(26, 6, 2, 1, 0, 0);
      27: return taps_from(27, 5, 2, 1, 0, 0);
      28: return taps_from(28, 25, 0, 0, 0, 0);
      29: return taps_from(29, 27, 0, 0, 0, 0);
      30: return taps_from(30, 6, 4, 1, 0, 0);
      31: return taps_from(31, 28, 0, 0, 0, 0);
      32: return taps_from(32, 22, 2, 1, 0, 0);
      33: return taps_from(33, 20, 0, 0, 0, 0);
      34: return taps_from(34, 27, 2, 1, 0, 0);
      35: return taps_from(35, 33, 0, 0, 0, 0);
      36: return taps_from(36, 25, 0, 0, 0, 0);
      37: return taps_from(37, 5, 4, 3, 2, 1);
      38: return taps_from(38, 6, 5, 1, 0, 0);
      39: return taps_from(39, 35, 0, 0, 0, 0);
      40: return taps_from(40, 38, 21, 19, 0, 0);
      41: return taps_from(41, 38, 0, 0, 0, 0);
      42: return taps_from(42, 41, 20, 19, 0, 0);
      43: return taps_from(43, 42, 38, 37, 0, 0);
      44: return taps_from(44, 43, 18, 17, 0, 0);
      45: return taps_from(45, 44, 42, 41, 0, 0);
      46: return taps_from(46, 45, 26, 25, 0, 0);
      47: return taps_from(47, 42, 0, 0, 0, 0);
      48: return taps_from(48, 47, 21, 20, 0, 0);
      49: return taps_from(49, 40, 0, 0, 0, 0);
      50: return taps_from(50, 49, 24, 23, 0, 0);
      51: return taps_from(51, 50, 36, 35, 0, 0);
      52: return taps_from(52, 49, 0, 0, 0, 0);
      53: return taps_from(53, 52, 38, 37, 0, 0);
      54: return taps_from(54, 53, 18, 17, 0, 0);
      55: return taps_from(55, 31, 0, 0, 0, 0);
      56: return taps_from(56, 55, 35, 34, 0, 0);
      57: return taps_from(57, 50, 0, 0, 0, 0);
      58: return taps_from(58, 39, 0, 0, 0, 0);
      59: return taps_from(59, 58, 38, 37, 0, 0);
      60: return taps_from(60, 59, 0, 0, 0, 0);
      61: return taps_from(61, 60, 46, 45, 0, 0);
      62: return taps_from(62, 61, 6, 5, 0, 0);
      63: return taps_from(63, 62, 0, 0, 0, 0);
      64: return taps_from(64, 63, 61, 60, 0, 0);
      default: return taps_from(16, 15, 13, 4, 0, 0);
    endcase
  endfunction

  // One Galois step: LSB feeds back into the MSB and into every tapped bit.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] v,
                                                      input logic [LFSR_MAX_W-1:0] taps,
                                                      input int size);
    logic [LFSR_MAX_W-1:0] r;
    r = '0;
    for (int k = 0; k < LFSR_MAX_W - 1; k++)
      if (k < size - 1) r[k] = v[k+1] ^ (taps[k] & v[0]);
    r = r | (LFSR_MAX_W'(v[0]) << (size - 1));
    return r;
  endfunction

endpackage

// File: rtl/std_lfsr_galois.sv
// Galois LFSR register: steps on i_en, loads i_setval when i_set is also high.
module std_lfsr_galois
  import std_lfsr_pkg::*;
#(
  parameter int              SIZE   = 16,
  parameter logic [SIZE-1:0] TAPVEC = SIZE'(taps_default(SIZE))
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_set,
  input  logic [SIZE-1:0] i_setval,
  output logic [SIZE-1:0] o_state
);

  logic [SIZE-1:0] state_step;

  assign state_step = SIZE'(lfsr_step(LFSR_MAX_W'(o_state), LFSR_MAX_W'(TAPVEC), SIZE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_state <= '0;
    else if (i_en) o_state <= i_set ? i_setval : state_step;
  end

endmodule

// File: rtl/std_prbs_checker.sv
// PRBS checker: predicts the next received Galois word, acquires lock after
// LOCK_CNT consecutive matches and drops it after LOSS_CNT consecutive misses.
module std_prbs_checker
  import std_lfsr_pkg::*;
#(
  parameter int              SIZE     = 16,
  parameter logic [SIZE-1:0] TAPVEC   = SIZE'(taps_default(SIZE)),
  parameter int              LOCK_CNT = 4,
  parameter int              LOSS_CNT = 3,
  parameter int              ERR_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [SIZE-1:0]  i_data,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_match,
  output logic             o_mismatch,
  output logic             o_zero,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int                RUN_W     = $clog2(LOCK_CNT + 1);
  localparam int                MISS_W    = $clog2(LOSS_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

  prbs_state_t       state, state_nxt;
  logic [RUN_W-1:0]  run, run_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;
  logic [SIZE-1:0]   pred, seed;
  logic              reseed, err_inc;
  logic              match_nxt, mismatch_nxt, zero_nxt;
  logic              is_zero, hit;

  assign seed    = SIZE'(lfsr_step(LFSR_MAX_W'(i_data), LFSR_MAX_W'(TAPVEC), SIZE));
  assign is_zero = (i_data == '0);
  assign hit     = (i_data == pred);

  // Predictor free-runs on every valid word; reseed overrides with step(i_data).
  std_lfsr_galois #(
    .SIZE   (SIZE),
    .TAPVEC (TAPVEC)
  ) u_pred (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_valid),
    .i_set    (reseed),
    .i_setval (seed),
    .o_state  (pred)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      run        <= '0;
      miss       <= '0;
      o_match    <= 1'b0;
      o_mismatch <= 1'b0;
      o_zero     <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      miss       <= miss_nxt;
      o_match    <= match_nxt;
      o_mismatch <= mismatch_nxt;
      o_zero     <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    run_nxt      = run;
    miss_nxt     = miss;
    reseed       = 1'b0;
    err_inc      = 1'b0;
    match_nxt    = 1'b0;
    mismatch_nxt = 1'b0;
    zero_nxt     = 1'b0;
    if (i_valid) begin
      if (is_zero) begin
        // An all-zero word is a dead LFSR state: never a seed, always an error.
        zero_nxt     = 1'b1;
        mismatch_nxt = 1'b1;
        if (state == ST_LOCKED) begin
          err_inc = 1'b1;
          if (miss == MISS_LAST) begin
            state_nxt = ST_IDLE;
            miss_nxt  = '0;
            run_nxt   = '0;
          end else begin
            miss_nxt = miss + MISS_W'(1);
          end
        end else begin
          state_nxt = ST_IDLE;
          run_nxt   = '0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            reseed    = 1'b1;
            state_nxt = ST_SYNC;
            run_nxt   = '0;
          end
          ST_SYNC: begin
            if (hit) begin
              match_nxt = 1'b1;
              if (run == RUN_LAST) begin
                state_nxt = ST_LOCKED;
                run_nxt   = '0;
                miss_nxt  = '0;
              end else begin
                run_nxt = run + RUN_W'(1);
              end
            end else begin
              mismatch_nxt = 1'b1;
              run_nxt      = '0;
              reseed       = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              match_nxt = 1'b1;
              miss_nxt  = '0;
            end else begin
              mismatch_nxt = 1'b1;
              err_inc      = 1'b1;
              if (miss == MISS_LAST) begin
                state_nxt = ST_SYNC;
                miss_nxt  = '0;
                run_nxt   = '0;
                reseed    = 1'b1;
              end else begin
                miss_nxt = miss + MISS_W'(1);
              end
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            run_nxt   = '0;
            miss_nxt  = '0;
          end
        endcase
      end
    end
  end

  // Clear takes priority over a coincident increment; count sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           o_err_cnt <= '0;
    else if (i_clear)                       o_err_cnt <= '0;
    else if (err_inc && (o_err_cnt != '1))  o_err_cnt <= o_err_cnt + ERR_W'(1);
  end

  assign o_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_std_prbs_checker.sv
// Bench for std_prbs_checker (SIZE=4, taps 4'h9): vector table, corner
// sequences and a randomized stream against a behavioural model.
module tb_std_prbs_checker;

  localparam logic [3:0] TAPS = 4'h9;
  localparam int M_IDLE = 0, M_SYNC = 1, M_LOCK = 2;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_clear = 1'b0;
  logic [3:0]  i_data = '0;
  logic        locked, match, mismatch, zero;
  logic [15:0] err;
  logic        locked_s, match_s, mismatch_s, zero_s;
  logic [1:0]  err_s;

  std_prbs_checker #(.SIZE(4), .TAPVEC(TAPS), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_clear(i_clear),
    .o_locked(locked), .o_match(match), .o_mismatch(mismatch), .o_zero(zero), .o_err_cnt(err));

  std_prbs_checker #(.SIZE(4), .TAPVEC(TAPS), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_clear(i_clear),
    .o_locked(locked_s), .o_match(match_s), .o_mismatch(mismatch_s), .o_zero(zero_s),
    .o_err_cnt(err_s));

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference next word: shift right, LSB wraps to MSB and is xored into taps.
  function automatic logic [3:0] nxt(input logic [3:0] v);
    int r;
    r = int'(v) / 2;
    if (v[0]) r = (r + 8) ^ int'(TAPS & 4'b0111);
    return 4'(r);
  endfunction

  int         mst, mrun, mmiss, merr, merr_s;
  logic [3:0] mpred;
  bit         em, emm, ez;

  task automatic model_reset();
    mst = M_IDLE; mrun = 0; mmiss = 0; merr = 0; merr_s = 0; mpred = '0;
    em = 0; emm = 0; ez = 0;
  endtask

  task automatic model(input bit v, input logic [3:0] d, input bit c);
    bit inc;
    inc = 0; em = 0; emm = 0; ez = 0;
    if (v) begin
      if (d == 4'h0) begin
        ez = 1; emm = 1;
        if (mst == M_LOCK) begin
          inc = 1; mmiss++; mpred = nxt(mpred);
          if (mmiss >= 3) begin mst = M_IDLE; mmiss = 0; mrun = 0; end
        end else begin
          mst = M_IDLE; mrun = 0;
        end
      end else if (mst == M_IDLE) begin
        mpred = nxt(d); mst = M_SYNC; mrun = 0;
      end else if (mst == M_SYNC) begin
        if (d == mpred) begin
          em = 1; mrun++; mpred = nxt(mpred);
          if (mrun == 4) begin mst = M_LOCK; mmiss = 0; end
        end else begin
          emm = 1; mrun = 0; mpred = nxt(d);
        end
      end else begin
        if (d == mpred) begin em = 1; mmiss = 0; end
        else begin emm = 1; mmiss++; inc = 1; end
        mpred = nxt(mpred);
        if (mmiss == 3) begin mst = M_SYNC; mrun = 0; mmiss = 0; mpred = nxt(d); end
      end
    end
    if (c) begin merr = 0; merr_s = 0; end
    else if (inc) begin
      if (merr < 65535) merr++;
      if (merr_s < 3) merr_s++;
    end
  endtask

  task automatic cyc(input bit v, input logic [3:0] d, input bit c);
    i_valid = v; i_data = d; i_clear = c;
    @(posedge i_clk);
    model(v, d, c);
    @(negedge i_clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},   locked,   (mst == M_LOCK));
    chk({tag, ".match"},    match,    em);
    chk({tag, ".mismatch"}, mismatch, emm);
    chk({tag, ".zero"},     zero,     ez);
    chk({tag, ".err"},      err,      merr);
    chk({tag, ".err_s"},    err_s,    merr_s);
    chk({tag, ".locked_s"}, locked_s, (mst == M_LOCK));
  endtask

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         m, mm, z, lk;
    int         e;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Sequence from 0001: 1 9 D F E 7 A 5 B C 6 3 8 4 2
    tbl[0]  = '{1, 4'h1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 4'h9, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 4'hD, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 4'hF, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 4'hE, 1, 0, 0, 1, 0};
    tbl[5]  = '{1, 4'h6, 0, 1, 0, 1, 1};  // 7 with bit0 flipped
    tbl[6]  = '{1, 4'hA, 1, 0, 0, 1, 1};
    tbl[7]  = '{1, 4'h5, 1, 0, 0, 1, 1};
    tbl[8]  = '{0, 4'h0, 0, 0, 0, 1, 1};  // idle cycle holds everything
    tbl[9]  = '{1, 4'hB, 1, 0, 0, 1, 1};
    tbl[10] = '{1, 4'h1, 0, 1, 0, 1, 2};  // jump to unrelated phase
    tbl[11] = '{1, 4'h9, 0, 1, 0, 1, 3};
    tbl[12] = '{1, 4'hD, 0, 1, 0, 0, 4};
    tbl[13] = '{1, 4'hF, 1, 0, 0, 0, 4};
    tbl[14] = '{1, 4'hE, 1, 0, 0, 0, 4};
    tbl[15] = '{1, 4'h7, 1, 0, 0, 0, 4};
    tbl[16] = '{1, 4'hA, 1, 0, 0, 1, 4};
    tbl[17] = '{1, 4'h0, 0, 1, 1, 1, 5};  // zero word while locked
    tbl[18] = '{1, 4'hB, 1, 0, 0, 1, 5};

    model_reset();
    @(negedge i_clk); @(negedge i_clk);
    chk("rst.locked", locked, 0);
    chk("rst.match", match, 0);
    chk("rst.mismatch", mismatch, 0);
    chk("rst.zero", zero, 0);
    chk("rst.err", err, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].v, tbl[i].d, 0);
      chk($sformatf("vec%0d.match", i),    match,    tbl[i].m);
      chk($sformatf("vec%0d.mismatch", i), mismatch, tbl[i].mm);
      chk($sformatf("vec%0d.zero", i),     zero,     tbl[i].z);
      chk($sformatf("vec%0d.locked", i),   locked,   tbl[i].lk);
      chk($sformatf("vec%0d.err", i),      err,      tbl[i].e);
      chk($sformatf("vec%0d.err_s", i),    err_s,    (tbl[i].e > 3) ? 3 : tbl[i].e);
    end

    // Saturated narrow counter holds; clear beats a coincident mismatch.
    cyc(1, 4'h1, 0);
    chk("sat.hold", err_s, 3);
    chk("sat.wide", err, 6);
    cyc(1, 4'h2, 1);
    chk("clr.err", err, 0);
    chk("clr.err_s", err_s, 0);
    chk("clr.mismatch", mismatch, 1);
    cyc(1, 4'h3, 0);
    check_model("clr.after");

    // Asynchronous reset mid-lock, then a full relock.
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst.locked", locked, 0);
    chk("arst.err", err, 0);
    chk("arst.pulses", {match, mismatch, zero}, 0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1, 4'h7, 0); check_model("relock0");
    cyc(1, 4'hA, 0); check_model("relock1");
    cyc(1, 4'h5, 0); check_model("relock2");
    cyc(1, 4'hB, 0); check_model("relock3");
    cyc(1, 4'hC, 0); check_model("relock4");
    chk("relock.locked", locked, 1);

    // Zero word in IDLE must not seed the predictor.
    i_rst_n = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1, 4'h0, 0);
    chk("idlez.zero", zero, 1);
    check_model("idlez0");
    cyc(1, 4'h9, 0);
    chk("idlez.seed_nomis", mismatch, 0);
    check_model("idlez1");
    cyc(1, 4'hD, 0);
    chk("idlez.match", match, 1);
    check_model("idlez2");

    // Randomized stream, mostly in-phase with occasional faults.
    for (int n = 0; n < 800; n++) begin
      bit         v, c;
      logic [3:0] d;
      int         r;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 72)      d = (mpred != 0) ? mpred : 4'h1;
      else if (r < 82) d = mpred ^ (4'h1 << $urandom_range(0, 3));
      else if (r < 87) d = 4'h0;
      else             d = 4'($urandom_range(1, 15));
      c = ($urandom_range(0, 39) == 0);
      cyc(v, d, c);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
